// File: rtl/bram_fwft_fifo_pkg.sv
// Shared helpers for the block-RAM FIFO: size arithmetic and threshold sanity checks.
package fifo_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Total word capacity for a given RAM address width.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // True when both thresholds lie inside their legal ranges.
  function automatic bit thresh_ok(input int depth, input int af_thresh, input int ae_thresh);
    return (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/bram_fwft_fifo_if.sv
// Stream-side bundle of the FIFO: write side, read side, status and error flags.
interface bram_fwft_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dest_data;
  logic                  dest_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_err_flr;
  logic                  rd_err_flr;
  logic [ADDR_WIDTH:0]   data_cnt;

  modport master (
    output flush, src_data, wr_en, rd_en,
    input  dest_data, dest_valid, full, empty, almost_full, almost_empty,
           wr_err_flr, rd_err_flr, data_cnt
  );

  modport slave (
    input  flush, src_data, wr_en, rd_en,
    output dest_data, dest_valid, full, empty, almost_full, almost_empty,
           wr_err_flr, rd_err_flr, data_cnt
  );
endinterface

// File: rtl/bram_fwft_fifo_blockram.sv
// Simple dual-port RAM: port a writes, port b reads synchronously and holds dob while enb is low.
module blockram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dia,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dob
);
  logic [DATA_WIDTH-1:0] mem [(1 << ADDR_WIDTH)];

  // Port a: store the incoming word when both enables are set.
  always_ff @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
  end

  // Port b: registered read, output frozen while not enabled.
  always_ff @(posedge clk) begin
    if (enb) dob <= mem[addrb];
  end
endmodule

// File: rtl/bram_fwft_fifo.sv
// Block-RAM FIFO with selectable standard or first-word-fall-through read side,
// occupancy count, almost flags, synchronous flush and one-cycle error pulses.
module bram_fwft_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4
) (
  input logic            clk,
  input logic            rst_n,
  bram_fwft_fifo_if.slave bus
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);

  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("bram_fwft_fifo: AF_THRESH/AE_THRESH outside legal range");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  head_valid_q;
  logic                  rd_valid_q;
  logic                  wr_err_q;
  logic                  rd_err_q;
  logic                  full_w;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  prefetch;
  logic                  ram_rd;

  // A read in the same cycle never frees space, so acceptance looks only at the current count.
  assign full_w    = (cnt_q == DEPTH_CNT);
  assign wr_accept = !bus.flush && bus.wr_en && !full_w;
  assign rd_accept = !bus.flush && bus.rd_en &&
                     ((FWFT != 0) ? head_valid_q : (cnt_q != '0));

  // In FWFT mode the head register is refilled whenever RAM still holds words and the head is free.
  assign ram_cnt  = cnt_q - {{ADDR_WIDTH{1'b0}}, head_valid_q};
  assign prefetch = !bus.flush && (ram_cnt != '0) && (!head_valid_q || rd_accept);
  assign ram_rd   = (FWFT != 0) ? prefetch : rd_accept;

  // Pointers, occupancy and read-side valid state; flush mirrors reset synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt_q        <= '0;
      head_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt_q        <= '0;
      head_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_rd)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_accept, rd_accept})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      if (FWFT != 0) begin
        if (prefetch)       head_valid_q <= 1'b1;
        else if (rd_accept) head_valid_q <= 1'b0;
      end
      rd_valid_q <= rd_accept;
    end
  end

  // One-cycle error pulses for rejected requests; flushed requests are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else if (bus.flush) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && full_w;
      rd_err_q <= bus.rd_en && !rd_accept;
    end
  end

  blockram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .ena  (wr_accept),
    .wea  (wr_accept),
    .addra(wr_ptr),
    .dia  (bus.src_data),
    .enb  (ram_rd),
    .addrb(rd_ptr),
    .dob  (bus.dest_data)
  );

  assign bus.dest_valid   = (FWFT != 0) ? head_valid_q : rd_valid_q;
  assign bus.full         = full_w;
  assign bus.empty        = (FWFT != 0) ? !head_valid_q : (cnt_q == '0);
  assign bus.almost_full  = (cnt_q >= AF_CNT);
  assign bus.almost_empty = (cnt_q <= AE_CNT);
  assign bus.wr_err_flr   = wr_err_q;
  assign bus.rd_err_flr   = rd_err_q;
  assign bus.data_cnt     = cnt_q;
endmodule

// File: tb/tb_bram_fwft_fifo.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO (8 deep, AF=6, AE=2)
// driven in lockstep and compared every cycle against queue-based reference models.
module tb_bram_fwft_fifo;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic rst_n;
  logic flush_d;
  logic wr_d;
  logic rd_d;
  logic [DW-1:0] din_d;

  int compared;
  int mismatched;

  bram_fwft_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bs ();
  bram_fwft_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bf ();

  assign bs.flush = flush_d;
  assign bs.wr_en = wr_d;
  assign bs.rd_en = rd_d;
  assign bs.src_data = din_d;
  assign bf.flush = flush_d;
  assign bf.wr_en = wr_d;
  assign bf.rd_en = rd_d;
  assign bf.src_data = din_d;

  bram_fwft_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE))
    dut_std (.clk(clk), .rst_n(rst_n), .bus(bs));

  bram_fwft_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE))
    dut_fwft (.clk(clk), .rst_n(rst_n), .bus(bf));

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: queues hold every word the FIFO owns, oldest first.
  logic [DW-1:0] sq[$];
  bit            s_valid, s_known, s_werr, s_rerr;
  logic [DW-1:0] s_data;
  logic [DW-1:0] fq[$];
  bit            f_valid, f_werr, f_rerr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    fq.delete();
    s_valid = 0; s_known = 0; s_werr = 0; s_rerr = 0;
    f_valid = 0; f_werr = 0; f_rerr = 0;
  endtask

  // Advance both models by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit pop_ok, pf;
    int ram_words;
    if (flush_d) begin
      sq.delete();
      fq.delete();
      s_valid = 0; s_werr = 0; s_rerr = 0;
      f_valid = 0; f_werr = 0; f_rerr = 0;
    end else begin
      // Standard: read legal iff something is stored before this edge.
      s_werr  = wr_d && (sq.size() == DEPTH);
      s_rerr  = rd_d && (sq.size() == 0);
      s_valid = rd_d && (sq.size() != 0);
      if (s_valid) begin
        s_data  = sq.pop_front();
        s_known = 1;
      end
      if (wr_d && !s_werr) sq.push_back(din_d);
      // FWFT: pop legal iff the head word is presented; head is refilled from RAM words.
      f_werr    = wr_d && (fq.size() == DEPTH);
      pop_ok    = rd_d && f_valid;
      f_rerr    = rd_d && !f_valid;
      ram_words = fq.size() - (f_valid ? 1 : 0);
      pf        = (ram_words > 0) && (!f_valid || pop_ok);
      if (pop_ok) void'(fq.pop_front());
      f_valid   = pf ? 1'b1 : (pop_ok ? 1'b0 : f_valid);
      if (wr_d && !f_werr) fq.push_back(din_d);
    end
  endtask

  task automatic check_all();
    int sc, fc;
    sc = sq.size();
    fc = fq.size();
    checkOutput("std_cnt",   bs.data_cnt, sc);
    checkOutput("std_full",  bs.full, (sc == DEPTH));
    checkOutput("std_empty", bs.empty, (sc == 0));
    checkOutput("std_af",    bs.almost_full, (sc >= AF));
    checkOutput("std_ae",    bs.almost_empty, (sc <= AE));
    checkOutput("std_valid", bs.dest_valid, s_valid);
    checkOutput("std_werr",  bs.wr_err_flr, s_werr);
    checkOutput("std_rerr",  bs.rd_err_flr, s_rerr);
    if (s_known) checkOutput("std_data", bs.dest_data, s_data);
    checkOutput("fw_cnt",    bf.data_cnt, fc);
    checkOutput("fw_full",   bf.full, (fc == DEPTH));
    checkOutput("fw_empty",  bf.empty, !f_valid);
    checkOutput("fw_af",     bf.almost_full, (fc >= AF));
    checkOutput("fw_ae",     bf.almost_empty, (fc <= AE));
    checkOutput("fw_valid",  bf.dest_valid, f_valid);
    checkOutput("fw_werr",   bf.wr_err_flr, f_werr);
    checkOutput("fw_rerr",   bf.rd_err_flr, f_rerr);
    if (f_valid) checkOutput("fw_data", bf.dest_data, fq[0]);
  endtask

  // Drive one cycle of inputs, clock it, update the models, then compare just after the edge.
  task automatic applyStimulus(input bit f, input bit w, input bit r, input logic [DW-1:0] d);
    flush_d = f; wr_d = w; rd_d = r; din_d = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    flush_d = 0; wr_d = 0; rd_d = 0; din_d = '0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    #9 rst_n = 1'b1;

    $display("[TB] standard ordering");
    applyStimulus(0, 1, 0, 16'h0011);
    applyStimulus(0, 1, 0, 16'h0022);
    applyStimulus(0, 1, 0, 16'h0033);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, '0);
    idle(2);

    $display("[TB] fwft first-word latency");
    applyStimulus(0, 1, 0, 16'h00A5);
    applyStimulus(0, 0, 0, '0);
    checkOutput("fw_lat_valid", bf.dest_valid, 1);
    checkOutput("fw_lat_data", bf.dest_data, 16'h00A5);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 16'h0B00 + 16'(i));
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, '0);
    idle(2);

    $display("[TB] full boundary");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 16'h0100 + 16'(i));
    applyStimulus(0, 1, 1, 16'hDEAD);
    idle(1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, '0);
    idle(2);

    $display("[TB] empty boundary");
    applyStimulus(0, 1, 1, 16'h005A);
    idle(2);
    applyStimulus(0, 0, 1, '0);
    idle(2);

    $display("[TB] flush");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 16'h0200 + 16'(i));
    applyStimulus(1, 1, 1, 16'h0077);
    idle(2);

    $display("[TB] randomized traffic");
    for (int phase = 0; phase < 6; phase++) begin
      int wp, rp;
      wp = (phase % 3 == 0) ? 80 : ((phase % 3 == 1) ? 30 : 55);
      rp = (phase % 3 == 0) ? 30 : ((phase % 3 == 1) ? 80 : 55);
      for (int i = 0; i < 100; i++) begin
        applyStimulus(($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 99) < wp),
                      ($urandom_range(0, 99) < rp),
                      16'($urandom));
      end
    end

    $display("[TB] async reset mid-burst");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 16'h0300 + 16'(i));
    wr_d = 1; din_d = 16'h0399;
    #2 rst_n = 1'b0;
    wr_d = 0;
    model_reset();
    #1 check_all();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 16'h0400 + 16'(i));
    idle(10);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
